// File: rtl/vga_tile_renderer_if.sv
// Scan bus from the VGA sync generator into the pixel-colour stage.
// The generator drives it (master); the renderer consumes it (slave).
interface vga_tile_renderer_if;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       valid_in;
    logic       hsync_in;
    logic       vsync_in;

    modport master (output pixel_x, pixel_y, valid_in, hsync_in, vsync_in);
    modport slave  (input  pixel_x, pixel_y, valid_in, hsync_in, vsync_in);
endinterface

// File: rtl/vga_tile_renderer.sv
// Three-stage pixel pipeline: tile-map background from a sync RAM with one
// rotatable 32x32 colour-keyed sprite composited on top; syncs kept aligned.
module vga_tile_renderer #(
    parameter logic [11:0] BG_COLOR    = 12'h000,
    parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
    input  logic               clk_25m,
    input  logic               rst,
    vga_tile_renderer_if.slave scan,
    input  logic [9:0]         tank_x,
    input  logic [9:0]         tank_y,
    input  logic [1:0]         tank_dir,
    output logic [10:0]        map_addr,
    input  logic [1:0]         map_data,
    output logic [9:0]         sprite_addr,
    input  logic [11:0]        sprite_data,
    output logic [11:0]        rgb,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start
);

    typedef enum logic [1:0] {
        TILE_EMPTY = 2'd0,
        TILE_BRICK = 2'd1,
        TILE_STEEL = 2'd2,
        TILE_WATER = 2'd3
    } tile_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    localparam logic [9:0]  OFFSCREEN    = 10'd1023;
    localparam logic [11:0] MORTAR_COLOR = 12'h888;
    localparam logic [11:0] BRICK_COLOR  = 12'hA52;
    localparam logic [11:0] STEEL_EDGE   = 12'h666;
    localparam logic [11:0] STEEL_FACE   = 12'hCCC;
    localparam logic [11:0] WATER_COLOR  = 12'h03F;

    // ------------------------------------------------------------------
    // Frame latch: sprite pose only moves during vertical blanking.
    // ------------------------------------------------------------------
    logic [9:0] tx_q;
    logic [9:0] ty_q;
    dir_t       dir_q;
    logic       latch_now;

    assign latch_now = (scan.pixel_x == 10'd0) && (scan.pixel_y == 10'd480);

    // NOTE: sequential state uses <= so every register samples pre-edge
    // values; a blocking = would collapse neighbouring stages into one cycle.
    always_ff @(posedge clk_25m) begin
        if (rst) begin
            tx_q        <= OFFSCREEN;
            ty_q        <= OFFSCREEN;
            dir_q       <= DIR_UP;
            frame_start <= 1'b0;
        end else begin
            frame_start <= latch_now;
            if (latch_now) begin
                tx_q  <= tank_x;
                ty_q  <= tank_y;
                dir_q <= dir_t'(tank_dir);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 decode: tile index, sprite hit test and rotated ROM address.
    // ------------------------------------------------------------------
    logic [5:0]  col;
    logic [5:0]  row;
    logic [10:0] tile_idx;
    logic [10:0] px_w;
    logic [10:0] py_w;
    logic [10:0] tx_w;
    logic [10:0] ty_w;
    logic        in_sprite;
    logic [4:0]  sx;
    logic [4:0]  sy;
    logic [9:0]  spr_addr_d;

    // NOTE: every signal driven from always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        col        = scan.pixel_x[9:4];
        row        = scan.pixel_y[9:4];
        tile_idx   = ({5'd0, row} << 5) + ({5'd0, row} << 3) + {5'd0, col};

        px_w       = {1'b0, scan.pixel_x};
        py_w       = {1'b0, scan.pixel_y};
        tx_w       = {1'b0, tx_q};
        ty_w       = {1'b0, ty_q};
        in_sprite  = (px_w >= tx_w) && (px_w < tx_w + 11'd32) &&
                     (py_w >= ty_w) && (py_w < ty_w + 11'd32);

        // Only the low five bits survive, so subtract at that width.
        sx         = scan.pixel_x[4:0] - tx_q[4:0];
        sy         = scan.pixel_y[4:0] - ty_q[4:0];

        spr_addr_d = '0;
        if (in_sprite) begin
            case (dir_q)
                DIR_UP:    spr_addr_d = {sy, sx};
                DIR_RIGHT: spr_addr_d = {~sx, sy};
                DIR_DOWN:  spr_addr_d = {~sy, ~sx};
                DIR_LEFT:  spr_addr_d = {sx, ~sy};
                default:   spr_addr_d = {sy, sx};
            endcase
        end
    end

    logic       valid_s1;
    logic       hsync_s1;
    logic       vsync_s1;
    logic       in_sprite_s1;
    logic [3:0] lx_s1;
    logic [3:0] ly_s1;

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            map_addr     <= '0;
            sprite_addr  <= '0;
            valid_s1     <= 1'b0;
            hsync_s1     <= 1'b1;
            vsync_s1     <= 1'b1;
            in_sprite_s1 <= 1'b0;
            lx_s1        <= '0;
            ly_s1        <= '0;
        end else begin
            map_addr     <= scan.valid_in ? tile_idx : 11'd0;
            sprite_addr  <= spr_addr_d;
            valid_s1     <= scan.valid_in;
            hsync_s1     <= scan.hsync_in;
            vsync_s1     <= scan.vsync_in;
            in_sprite_s1 <= in_sprite;
            lx_s1        <= scan.pixel_x[3:0];
            ly_s1        <= scan.pixel_y[3:0];
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: procedural tile texture from the returned tile type.
    // ------------------------------------------------------------------
    logic [11:0] tile_color;

    always_comb begin
        tile_color = BG_COLOR;
        case (tile_t'(map_data))
            TILE_EMPTY: tile_color = BG_COLOR;
            TILE_BRICK: begin
                // Mortar every 8 rows and every 8 columns (lx == 8 included).
                if ((ly_s1[2:0] == 3'd0) || (lx_s1[2:0] == 3'd0) || (lx_s1 == 4'd8))
                    tile_color = MORTAR_COLOR;
                else
                    tile_color = BRICK_COLOR;
            end
            TILE_STEEL: begin
                if ((lx_s1 == 4'd0) || (lx_s1 == 4'd15) ||
                    (ly_s1 == 4'd0) || (ly_s1 == 4'd15))
                    tile_color = STEEL_EDGE;
                else
                    tile_color = STEEL_FACE;
            end
            TILE_WATER: tile_color = WATER_COLOR;
            default:    tile_color = BG_COLOR;
        endcase
    end

    logic [11:0] tile_s2;
    logic [11:0] sprite_s2;
    logic        valid_s2;
    logic        hsync_s2;
    logic        vsync_s2;
    logic        in_sprite_s2;

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            tile_s2      <= '0;
            sprite_s2    <= '0;
            valid_s2     <= 1'b0;
            hsync_s2     <= 1'b1;
            vsync_s2     <= 1'b1;
            in_sprite_s2 <= 1'b0;
        end else begin
            tile_s2      <= tile_color;
            sprite_s2    <= sprite_data;
            valid_s2     <= valid_s1;
            hsync_s2     <= hsync_s1;
            vsync_s2     <= vsync_s1;
            in_sprite_s2 <= in_sprite_s1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: composite, blank outside the active area.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_25m) begin
        if (rst) begin
            rgb   <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            if (!valid_s2)
                rgb <= '0;
            else if (in_sprite_s2 && (sprite_s2 != TRANSPARENT))
                rgb <= sprite_s2;
            else
                rgb <= tile_s2;
            hsync <= hsync_s2;
            vsync <= vsync_s2;
        end
    end

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Scoreboard bench for vga_tile_renderer: a behavioural screen model predicts
// each pixel and the expectation rides a queue until the pipeline delivers it.
`timescale 1ns/1ps
module tb_vga_tile_renderer;

    localparam logic [11:0] BG  = 12'h000;
    localparam logic [11:0] KEY = 12'hF0F;

    typedef struct {
        int          x;
        int          y;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    typedef struct {
        int          x;
        int          y;
        logic [11:0] rgb;
    } tile_vec_t;

    logic        clk_25m = 1'b0;
    logic        rst;
    logic [9:0]  tank_x;
    logic [9:0]  tank_y;
    logic [1:0]  tank_dir;
    logic [10:0] map_addr;
    logic [1:0]  map_data;
    logic [9:0]  sprite_addr;
    logic [11:0] sprite_data;
    logic [11:0] rgb;
    logic        hsync;
    logic        vsync;
    logic        frame_start;

    vga_tile_renderer_if scan ();

    vga_tile_renderer #(.BG_COLOR(BG), .TRANSPARENT(KEY)) dut (
        .clk_25m     (clk_25m),
        .rst         (rst),
        .scan        (scan),
        .tank_x      (tank_x),
        .tank_y      (tank_y),
        .tank_dir    (tank_dir),
        .map_addr    (map_addr),
        .map_data    (map_data),
        .sprite_addr (sprite_addr),
        .sprite_data (sprite_data),
        .rgb         (rgb),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start)
    );

    always #20 clk_25m = ~clk_25m;

    // Memories: the DUT's registered address feeds a combinational array read.
    logic [1:0] map_mem [0:1199];
    bit         rom_rich;

    assign map_data    = (map_addr < 11'd1200) ? map_mem[map_addr] : 2'd0;
    assign sprite_data = (sprite_addr == 10'd0) ? KEY :
                         (rom_rich ? (12'h400 | {2'b00, sprite_addr}) : 12'hF00);

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb [$];

    int   tk_x, tk_y, tk_dir;
    int   mtx, mty, mdir;

    bit          have_prev;
    logic        prev_latch;
    logic [10:0] prev_map;
    logic [9:0]  prev_spr;
    int          prev_x, prev_y;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [11:0] rom_word(input int a);
        if (a == 0) return KEY;
        if (rom_rich) return 12'h400 | 12'(a);
        return 12'hF00;
    endfunction

    // Sprite ROM index seen at screen (x,y), or -1 when outside the sprite.
    function automatic int spr_index(input int x, input int y);
        int sx, sy, r, c;
        if (x < mtx || x >= mtx + 32 || y < mty || y >= mty + 32) return -1;
        sx = x - mtx;
        sy = y - mty;
        case (mdir)
            0:       begin r = sy;      c = sx;      end
            1:       begin r = 31 - sx; c = sy;      end
            2:       begin r = 31 - sy; c = 31 - sx; end
            default: begin r = sx;      c = 31 - sy; end
        endcase
        return r * 32 + c;
    endfunction

    function automatic logic [11:0] tile_colour(input int x, input int y);
        int lx, ly;
        lx = x % 16;
        ly = y % 16;
        case (map_mem[(y / 16) * 40 + x / 16])
            2'd0: return BG;
            2'd1: return ((ly % 8 == 0) || (lx % 8 == 0)) ? 12'h888 : 12'hA52;
            2'd2: return (lx == 0 || lx == 15 || ly == 0 || ly == 15) ? 12'h666 : 12'hCCC;
            default: return 12'h03F;
        endcase
    endfunction

    function automatic logic [11:0] pixel_colour(input int x, input int y, input bit v);
        int          si;
        logic [11:0] w;
        if (!v) return 12'h000;
        si = spr_index(x, y);
        if (si >= 0) begin
            w = rom_word(si);
            if (w != KEY) return w;
        end
        return tile_colour(x, y);
    endfunction

    // One pixel clock: check what is due, then drive the next generator pixel.
    task automatic step(input int x, input int y, input bit use_rgb,
                        input logic [11:0] rgb_req, input int spr_req);
        exp_t e;
        int   si;
        bit   v, hs, vs;
        @(negedge clk_25m);
        if (have_prev) begin
            check($sformatf("frame_start after (%0d,%0d)", prev_x, prev_y), 32'(frame_start), 32'(prev_latch));
            check($sformatf("map_addr (%0d,%0d)", prev_x, prev_y), 32'(map_addr), 32'(prev_map));
            check($sformatf("sprite_addr (%0d,%0d)", prev_x, prev_y), 32'(sprite_addr), 32'(prev_spr));
        end
        if (sb.size() == 3) begin
            e = sb.pop_front();
            check($sformatf("rgb (%0d,%0d)", e.x, e.y), 32'(rgb), 32'(e.rgb));
            check($sformatf("hsync (%0d,%0d)", e.x, e.y), 32'(hsync), 32'(e.hs));
            check($sformatf("vsync (%0d,%0d)", e.x, e.y), 32'(vsync), 32'(e.vs));
        end
        v  = (x < 640) && (y < 480);
        hs = !(x >= 655 && x <= 750);
        vs = !(y >= 490 && y <= 491);
        scan.pixel_x  = 10'(x);
        scan.pixel_y  = 10'(y);
        scan.valid_in = v;
        scan.hsync_in = hs;
        scan.vsync_in = vs;
        tank_x        = 10'(tk_x);
        tank_y        = 10'(tk_y);
        tank_dir      = 2'(tk_dir);

        e.x   = x;
        e.y   = y;
        e.rgb = use_rgb ? rgb_req : pixel_colour(x, y, v);
        e.hs  = hs;
        e.vs  = vs;
        sb.push_back(e);

        si = spr_index(x, y);
        if (spr_req >= 0)  prev_spr = 10'(spr_req);
        else if (si >= 0)  prev_spr = 10'(si);
        else               prev_spr = 10'd0;
        prev_map   = v ? 11'((y / 16) * 40 + x / 16) : 11'd0;
        prev_latch = (x == 0) && (y == 480);
        prev_x     = x;
        prev_y     = y;
        have_prev  = 1'b1;
        if (prev_latch) begin
            mtx  = tk_x;
            mty  = tk_y;
            mdir = tk_dir;
        end
    endtask

    task automatic px(input int x, input int y);
        step(x, y, 1'b0, 12'h000, -1);
    endtask

    task automatic scan_row(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) px(x, y);
    endtask

    task automatic drain();
        repeat (3) px(700, 10);
    endtask

    // Reset with busy, sync-low inputs (including the latch pixel) to prove
    // that outputs and the latch ignore them while rst is high.
    task automatic do_reset(input int cycles);
        @(negedge clk_25m);
        rst           = 1'b1;
        scan.pixel_x  = 10'd0;
        scan.pixel_y  = 10'd480;
        scan.valid_in = 1'b1;
        scan.hsync_in = 1'b0;
        scan.vsync_in = 1'b0;
        sb.delete();
        have_prev = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_25m);
            check($sformatf("reset rgb cyc%0d", i), 32'(rgb), 32'h0);
            check($sformatf("reset hsync cyc%0d", i), 32'(hsync), 32'h1);
            check($sformatf("reset vsync cyc%0d", i), 32'(vsync), 32'h1);
            check($sformatf("reset frame_start cyc%0d", i), 32'(frame_start), 32'h0);
            check($sformatf("reset map_addr cyc%0d", i), 32'(map_addr), 32'h0);
            check($sformatf("reset sprite_addr cyc%0d", i), 32'(sprite_addr), 32'h0);
        end
        scan.pixel_x  = 10'd700;
        scan.pixel_y  = 10'd10;
        scan.valid_in = 1'b0;
        scan.hsync_in = 1'b1;
        scan.vsync_in = 1'b1;
        rst  = 1'b0;
        mtx  = 1023;
        mty  = 1023;
        mdir = 0;
    endtask

    initial begin
        tile_vec_t tiles [12];
        tile_vec_t spr_vecs [4];
        int        rot_exp [4];

        rst           = 1'b1;
        scan.pixel_x  = 10'd700;
        scan.pixel_y  = 10'd10;
        scan.valid_in = 1'b0;
        scan.hsync_in = 1'b1;
        scan.vsync_in = 1'b1;
        tk_x = 100; tk_y = 50; tk_dir = 0;
        tank_x = 10'd100; tank_y = 10'd50; tank_dir = 2'd0;
        rom_rich = 1'b0;
        for (int i = 0; i < 1200; i++) map_mem[i] = 2'd0;
        map_mem[1]          = 2'd1;   // row 0, col 1: brick
        map_mem[80]         = 2'd2;   // row 2, col 0: steel
        map_mem[3 * 40 + 2] = 2'd3;   // water
        map_mem[3 * 40 + 6] = 2'd1;   // under the sprite
        map_mem[3 * 40 + 8] = 2'd2;

        tiles = '{
            '{17, 1,  12'hA52}, '{16, 0,  12'h888}, '{0,  32, 12'h666},
            '{1,  33, 12'hCCC}, '{24, 5,  12'h888}, '{20, 3,  12'hA52},
            '{18, 8,  12'h888}, '{5,  5,  12'h000}, '{15, 40, 12'h666},
            '{14, 47, 12'h666}, '{37, 53, 12'h03F}, '{660, 1, 12'h000}
        };
        spr_vecs = '{
            '{100, 50, 12'hA52}, '{101, 50, 12'hF00},
            '{131, 50, 12'hF00}, '{132, 50, 12'hCCC}
        };
        rot_exp = '{0, 992, 1023, 31};

        do_reset(2);

        // Background tiles, sprite still parked off-screen.
        for (int i = 0; i < 12; i++)
            step(tiles[i].x, tiles[i].y, 1'b1, tiles[i].rgb, -1);
        drain();
        scan_row(50, 96, 140);

        // Sync alignment and blanking around the end of the active line.
        scan_row(10, 600, 799);
        scan_row(490, 0, 20);

        // Latch dir 0 at (100,50) and check colour keying.
        tk_x = 100; tk_y = 50; tk_dir = 0;
        px(0, 480);
        for (int i = 0; i < 4; i++)
            step(spr_vecs[i].x, spr_vecs[i].y, 1'b1, spr_vecs[i].rgb, -1);
        scan_row(50, 96, 140);
        scan_row(81, 96, 140);
        scan_row(82, 96, 140);
        drain();

        // Rotations, with an address-dependent ROM so every pixel differs.
        rom_rich = 1'b1;
        for (int d = 1; d < 4; d++) begin
            tk_dir = d;
            px(0, 480);
            step(100, 50, 1'b0, 12'h000, rot_exp[d]);
            scan_row(60, 98, 134);
        end

        // Pose change mid-frame stays invisible until the next latch.
        tk_x = 100; tk_y = 96; tk_dir = 0;
        px(0, 480);
        for (int x = 90; x <= 240; x++) begin
            if (x == 150) tk_x = 220;
            px(x, 100);
        end
        px(799, 479);
        tk_x = 200;
        px(0, 480);
        tk_x = 260;
        px(1, 480);
        scan_row(100, 90, 240);

        // Clipping at the right/bottom edges and a fully off-screen pose.
        tk_x = 630; tk_y = 470;
        px(0, 480);
        scan_row(475, 620, 660);
        scan_row(479, 620, 645);
        tk_x = 1009; tk_y = 1009;
        px(0, 480);
        scan_row(0, 0, 20);
        scan_row(479, 630, 639);

        // Reset mid-line drops the sprite until the next latch.
        tk_x = 200; tk_y = 96; tk_dir = 1;
        px(0, 480);
        scan_row(100, 190, 210);
        do_reset(2);
        scan_row(100, 190, 240);
        px(0, 480);
        scan_row(100, 195, 235);
        drain();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_tile_renderer.md
# vga_tile_renderer

Pixel-colour stage directly downstream of the VGA scan/sync generator. Consumes the generator's `pixel_x`/`pixel_y`/`valid`/`hsync`/`vsync` at 25 MHz. Fetches the background tile type from a synchronous map RAM and composites one rotatable 32×32 tank sprite over it. Emits 12-bit RGB with the sync signals delayed to stay aligned.

## Interface

Parameters:

- `BG_COLOR`, 12'h000: colour of empty tiles.
- `TRANSPARENT`, 12'hF0F: sprite colour key that lets the tile show through.

Ports:

- `clk_25m`  in  1  pixel clock.
- `rst`  in  1  synchronous reset, active-high.
- `pixel_x`  in  10  scan column from the sync generator (0..799).
- `pixel_y`  in  10  scan row (0..524).
- `valid_in`  in  1  high inside the 640×480 active area.
- `hsync_in`, `vsync_in`  in  1  active-low syncs from the generator.
- `tank_x`, `tank_y`  in  10  sprite top-left corner in screen pixels.
- `tank_dir`  in  2  0 up, 1 right, 2 down, 3 left.
- `map_addr`  out  11  tile index into the 40×30 map (0..1199).
- `map_data`  in  2  tile type; valid the cycle after `map_addr`.
- `sprite_addr`  out  10  {row[4:0], col[4:0]} into the up-facing sprite ROM.
- `sprite_data`  in  12  sprite pixel; valid the cycle after `sprite_addr`.
- `rgb`  out  12  {R[3:0], G[3:0], B[3:0]}.
- `hsync`, `vsync`  out  1  `hsync_in`/`vsync_in` delayed 3 cycles.
- `frame_start`  out  1  one-cycle pulse when the sprite position is latched.

## Operation

- **Frame latch.** On the cycle where the input is `pixel_x==0 && pixel_y==480`:
  - `tank_x`, `tank_y` and `tank_dir` are captured into `tx_q`, `ty_q`, `dir_q`.
  - `frame_start` is high on the following cycle.
  - Input changes at any other time have no effect until the next latch, so the sprite never tears mid-frame.
  - Reset values: `tx_q = ty_q = 1023`, which places the sprite off-screen. `dir_q = 0`.
- **Stage 1** (registered at edge n+1 for the input at cycle n):
  - `col = pixel_x[9:4]`, `row = pixel_y[9:4]`.
  - `map_addr = row*40 + col`, computed as `(row<<5)+(row<<3)+col` in 11 bits.
  - When `valid_in = 0`, `map_addr` is driven as 0.
  - In-sprite flag: `pixel_x >= tx_q`, `pixel_x < tx_q+32`, `pixel_y >= ty_q` and `pixel_y < ty_q+32`, all compared at 11-bit width so nothing wraps.
  - Local sprite coordinates: `sx = pixel_x - tx_q`, `sy = pixel_y - ty_q`, each truncated to 5 bits.
  - `sprite_addr` as {row, col}, selected by `dir_q`:
    - 0 (up): {sy, sx}.
    - 1 (right): {31-sx, sy}.
    - 2 (down): {31-sy, 31-sx}.
    - 3 (left): {sx, 31-sy}.
  - `sprite_addr` is 0 when not in-sprite.
  - Also delayed into stage 1: `valid`, syncs, in-sprite flag, tile-local `lx = pixel_x[3:0]`, `ly = pixel_y[3:0]`.
- **Stage 2** (edge n+2): tile colour from `map_data` with the delayed `lx`/`ly`:
  - 0, empty: `BG_COLOR`.
  - 1, brick: 12'h888 if `ly[2:0]==0`, `lx[2:0]==0` or `lx==8` (mortar); otherwise 12'hA52.
  - 2, steel: 12'h666 if `lx` or `ly` is 0 or 15; otherwise 12'hCCC.
  - 3, water: 12'h03F.
  - `sprite_data` is registered alongside; the other delayed controls advance one stage.
- **Stage 3** (edge n+3):
  - `rgb = 0` if the delayed `valid` is 0.
  - Otherwise `rgb = sprite_data` if in-sprite and `sprite_data != TRANSPARENT`.
  - Otherwise `rgb` is the tile colour.
  - `hsync`/`vsync` register their stage-2 copies.
- **Edge cases.**
  - A sprite partly beyond x=639 or y=479 is clipped by `valid`.
  - `tank_x`/`tank_y` ≥ 1009 never overlap the active area.

## Timing

- Fixed latency of 3 cycles from inputs to `rgb`/`hsync`/`vsync`. No stalls and no handshake: one pixel per clock, always.
- The RAM and ROM must return data exactly one cycle after the address, which is a registered-address synchronous read.
- Reset state for all pipeline registers and outputs:
  - `rgb = 0`, `hsync = 1`, `vsync = 1`.
  - `frame_start = 0`, `map_addr = 0`, `sprite_addr = 0`.
- Reset asserted mid-frame:
  - Outputs take their reset values at the next edge.
  - The latched sprite returns off-screen until the next y=480 latch.
- Simultaneous change of `tank_*` on the latch cycle: the value present on that cycle is the one captured.

## Test plan

- Reset: assert `rst` 2 cycles mid-line -> `rgb=0`, `hsync=vsync=1`, `frame_start=0` at the next edge; no sprite drawn before the first y=480 latch.
- Latency and sync: drive a generator-like scan with `hsync_in` low for x=655..750 -> `hsync` low from the edge 3 cycles after x=655 through 3 cycles after x=750; `rgb=0` whenever the delayed `valid` is 0.
- Tiles: map tile (row 0, col 1) = 1 and tile (row 2, col 0) = 2 -> `map_addr` 1 and 80 seen; at (x=17, y=1) `rgb=12'hA52`; at (x=16, y=0) `rgb=12'h888`; at (x=0, y=32) `rgb=12'h666`; at (x=1, y=33) `rgb=12'hCCC`.
- Sprite and transparency: latch `tank_x=100`, `tank_y=50`, dir 0; ROM returns `TRANSPARENT` at {0,0} and 12'hF00 elsewhere -> (100,50) shows the tile colour; (101,50) shows 12'hF00; (132,50) shows the tile colour.
- Rotation: with the same position, at screen (100,50) -> dir 1 gives `sprite_addr={31,0}`; dir 2 gives {31,31}; dir 3 gives {0,31}.
- Frame latch: change `tank_x` from 100 to 200 at y=100 -> the current frame still draws at x=100; `frame_start` pulses one cycle after the input (0,480); the next frame draws at x=200.
